// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// controller state encoding, default widths and a saturating increment.
package seq_det_pkg;

   localparam int unsigned DEF_PAT_W = 4;
   localparam int unsigned DEF_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Increment v, holding at the all-ones value of a w-bit field.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] lim;
      lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return (v >= lim) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/seq_det_core.sv
// Pattern matching datapath: history shift register, fill counter and a
// combinational compare of the would-be next history against the pattern.
module seq_det_core
   import seq_det_pkg::*;
#(
   parameter int unsigned PAT_W = DEF_PAT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             overlap,
   input  logic             in_bit,
   input  logic [PAT_W-1:0] pattern,
   output logic             match
);

   localparam int unsigned FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  r_hist;
   logic [FILL_W-1:0] r_fill;
   logic [PAT_W-1:0]  w_hist_n;
   logic [FILL_W-1:0] w_fill_n;

   // Next history/fill for an accepted bit and the match it would produce.
   always_comb begin
      w_hist_n = {r_hist[PAT_W-2:0], in_bit};
      w_fill_n = (r_fill >= FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
      match    = (w_hist_n == pattern) && (w_fill_n == FILL_FULL);
   end

   // History and fill update; a non-overlapping match restarts the fill.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (shift_en) begin
         r_hist <= w_hist_n;
         r_fill <= (match && !overlap) ? '0 : w_fill_n;
      end
   end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-controlled serial pattern detector: configuration latch, run FSM,
// saturating match counter and registered one-cycle match pulse.
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int unsigned PAT_W = DEF_PAT_W,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic             cfg_overlap,
   input  logic             start,
   input  logic             abort,
   input  logic             in,
   input  logic             in_valid,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy,
   output logic             done
);

   state_t           r_state;
   state_t           w_state_n;
   logic [PAT_W-1:0] r_pattern_q;
   logic [CNT_W-1:0] r_target_q;
   logic             r_overlap_q;
   logic             r_out;
   logic [CNT_W-1:0] r_cnt;

   logic             w_armable;
   logic             w_start;
   logic             w_accept;
   logic             w_core_match;
   logic             w_match;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_hit_target;

   // Qualified control strobes; abort discards a same-cycle data bit.
   always_comb begin
      w_armable    = (r_state == IDLE) || (r_state == DONE);
      w_start      = start && w_armable;
      w_accept     = (r_state == RUN) && in_valid && !abort;
      w_match      = w_accept && w_core_match;
      w_cnt_inc    = CNT_W'(sat_inc(32'(r_cnt), CNT_W));
      w_hit_target = w_match && (r_target_q != '0) && (w_cnt_inc == r_target_q);
   end

   seq_det_core #(
      .PAT_W (PAT_W)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_start),
      .shift_en (w_accept),
      .overlap  (r_overlap_q),
      .in_bit   (in),
      .pattern  (r_pattern_q),
      .match    (w_core_match)
   );

   // Run state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_n;
   end

   // Next-state logic; the unused encoding recovers to IDLE.
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         IDLE, DONE: if (start) w_state_n = RUN;
         RUN: begin
            if (abort)             w_state_n = IDLE;
            else if (w_hit_target) w_state_n = DONE;
         end
         default: w_state_n = IDLE;
      endcase
   end

   // Configuration latch, writable only outside a run.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pattern_q <= '0;
         r_target_q  <= '0;
         r_overlap_q <= 1'b0;
      end else if (cfg_load && w_armable) begin
         r_pattern_q <= cfg_pattern;
         r_target_q  <= cfg_target;
         r_overlap_q <= cfg_overlap;
      end
   end

   // Match pulse and saturating match counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_out <= w_match;
         if (w_start)      r_cnt <= '0;
         else if (w_match) r_cnt <= w_cnt_inc;
      end
   end

   assign out       = r_out;
   assign match_cnt = r_cnt;
   assign busy      = (r_state == RUN);
   assign done      = (r_state == DONE);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: expected per-cycle outputs are queued as
// each step is driven and checked one edge later.
module tb_seq_det_ctrl;

   localparam int unsigned PAT_W = 4;
   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cfg_load = 1'b0;
   logic [PAT_W-1:0] cfg_pattern = '0;
   logic [CNT_W-1:0] cfg_target = '0;
   logic             cfg_overlap = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             in = 1'b0;
   logic             in_valid = 1'b0;
   logic             out;
   logic [CNT_W-1:0] match_cnt;
   logic             busy;
   logic             done;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic       o;
      logic [7:0] cnt;
      logic       b;
      logic       d;
   } exp_t;

   exp_t sb[$];

   seq_det_ctrl #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_target  (cfg_target),
      .cfg_overlap (cfg_overlap),
      .start       (start),
      .abort       (abort),
      .in          (in),
      .in_valid    (in_valid),
      .out         (out),
      .match_cnt   (match_cnt),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic o, input logic [7:0] c, input logic b, input logic d);
      return exp_t'({o, c, b, d});
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock step: drive controls, queue expectation, check after the edge.
   task automatic cyc(input string tag, input logic b, input logic v, input logic ab,
                      input logic st, input logic ld, input logic r, input exp_t e);
      exp_t got;
      in = b; in_valid = v; abort = ab; start = st; cfg_load = ld; rst = r;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({tag, ".out"},  32'(out),       32'(got.o));
      chk({tag, ".cnt"},  32'(match_cnt), 32'(got.cnt));
      chk({tag, ".busy"}, 32'(busy),      32'(got.b));
      chk({tag, ".done"}, 32'(done),      32'(got.d));
      in_valid = 1'b0; abort = 1'b0; start = 1'b0; cfg_load = 1'b0; rst = 1'b0;
   endtask

   // Feed n valid bits (seq[n-1] first); pul marks the bits that complete a match.
   task automatic feed(input string tag, input int unsigned n, input logic [15:0] seq,
                       input logic [15:0] pul, input logic [7:0] c0, input logic b, input logic d);
      logic [7:0] c;
      c = c0;
      for (int i = int'(n) - 1; i >= 0; i--) begin
         c = c + 8'(pul[i]);
         cyc($sformatf("%s_b%0d", tag, int'(n) - i), seq[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
             mk(pul[i], c, b, d));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      cyc("reset", 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0));
      chk("reset.pattern_q", 32'(dut.r_pattern_q), 32'h0);

      // 1: overlapping detection, config loaded together with start
      cfg_pattern = 4'b1011; cfg_target = 8'd0; cfg_overlap = 1'b1;
      cyc("t1_arm", 0, 0, 0, 1, 1, 0, mk(0, 0, 1, 0));
      feed("t1", 7, 16'b1011011, 16'b0001001, 8'd0, 1'b1, 1'b0);

      // 2: non-overlapping detection
      cyc("t2_abort", 0, 0, 1, 0, 0, 0, mk(0, 2, 0, 0));
      cfg_overlap = 1'b0;
      cyc("t2_arm", 0, 0, 0, 1, 1, 0, mk(0, 0, 1, 0));
      feed("t2", 7, 16'b1011011, 16'b0001000, 8'd0, 1'b1, 1'b0);
      chk("t2.fill", 32'(dut.u_core.r_fill), 32'd3);

      // 3: run stops at the target count
      cyc("t3_abort", 0, 0, 1, 0, 0, 0, mk(0, 1, 0, 0));
      cfg_overlap = 1'b1; cfg_target = 8'd2;
      cyc("t3_arm", 0, 0, 0, 1, 1, 0, mk(0, 0, 1, 0));
      feed("t3", 7, 16'b1011101, 16'b0001000, 8'd0, 1'b1, 1'b0);
      cyc("t3_b8", 1, 1, 0, 0, 0, 0, mk(1, 2, 0, 1));
      feed("t3_post", 4, 16'b1011, 16'b0000, 8'd2, 1'b0, 1'b1);
      cfg_target = 8'd0;
      cyc("t3_load_in_done", 0, 0, 0, 0, 1, 0, mk(0, 2, 0, 1));

      // 4: gaps in in_valid hold the history
      cyc("t4_arm", 0, 0, 0, 1, 0, 0, mk(0, 0, 1, 0));
      feed("t4a", 2, 16'b10, 16'b00, 8'd0, 1'b1, 1'b0);
      for (int g = 0; g < 3; g++)
         cyc($sformatf("t4_gap%0d", g), 1, 0, 0, 0, 0, 0, mk(0, 0, 1, 0));
      feed("t4b", 2, 16'b11, 16'b01, 8'd0, 1'b1, 1'b0);

      // 5: abort outranks a completing bit; re-arm clears fill; load ignored in RUN
      feed("t5a", 3, 16'b101, 16'b000, 8'd1, 1'b1, 1'b0);
      cyc("t5_abort", 1, 1, 1, 0, 0, 0, mk(0, 1, 0, 0));
      cyc("t5_idle", 0, 0, 0, 0, 0, 0, mk(0, 1, 0, 0));
      cyc("t5_rearm", 0, 0, 0, 1, 0, 0, mk(0, 0, 1, 0));
      feed("t5b", 1, 16'b1, 16'b0, 8'd0, 1'b1, 1'b0);
      cfg_pattern = 4'b0000;
      cyc("t5_load_run", 0, 1, 0, 0, 1, 0, mk(0, 0, 1, 0));
      chk("t5.pattern_q", 32'(dut.r_pattern_q), 32'hb);
      feed("t5c", 2, 16'b11, 16'b01, 8'd0, 1'b1, 1'b0);

      // 6: reset mid-pattern with the completing bit in the reset cycle
      cyc("t6_abort", 0, 0, 1, 0, 0, 0, mk(0, 1, 0, 0));
      cfg_pattern = 4'b1011;
      cyc("t6_arm", 0, 0, 0, 1, 1, 0, mk(0, 0, 1, 0));
      feed("t6", 3, 16'b101, 16'b000, 8'd0, 1'b1, 1'b0);
      chk("t6.fill", 32'(dut.u_core.r_fill), 32'd3);
      cyc("t6_rst", 1, 1, 0, 0, 0, 1, mk(0, 0, 0, 0));
      chk("t6.pattern_q", 32'(dut.r_pattern_q), 32'h0);
      cyc("t6_after", 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable, run-controlled serial pattern detector with match scheduling. Software loads a pattern, a match target and an overlap mode. It arms the detector with start and then receives a registered Moore match pulse per detected pattern. A running match count is kept, and the block stops itself after the target count. It sits between the config/control interface and the serial bit stream, replacing hard-coded fixed-pattern FSM detectors.

Parameters:
PAT_W, 4, pattern length in bits (2..16); the first received bit is compared against cfg_pattern[PAT_W-1]
CNT_W, 8, width of the match counter and target

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
cfg_load  in  1  latch cfg_pattern, cfg_target and cfg_overlap; accepted only when busy=0
cfg_pattern  in  PAT_W  pattern to detect, MSB received first
cfg_target  in  CNT_W  match count at which the run ends; 0 means run forever
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
start  in  1  arm a run; accepted only when busy=0
abort  in  1  terminate the current run
in  in  1  serial data bit
in_valid  in  1  in is sampled only when in_valid=1 and state=RUN
out  out  1  registered one-cycle match pulse
match_cnt  out  CNT_W  matches detected in the current or last run
busy  out  1  1 while state=RUN
done  out  1  level; target reached

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. rst is sampled only at the clk edge.
- rst resets all registers:
  - state=IDLE
  - pattern_q, target_q, overlap_q = 0
  - hist=0, fill=0
  - out=0, match_cnt=0, busy=0, done=0
- rst mid-run aborts immediately with no pulse.
- State machine: IDLE(00), RUN(01), DONE(10); encoding 11 goes to IDLE.
- IDLE or DONE:
  - cfg_load latches the configuration.
  - start moves to RUN, clears hist, fill, match_cnt and done, and sets busy=1 at the same edge.
  - If cfg_load and start are both high, the newly loaded configuration applies to this run.
- RUN:
  - cfg_load and start are ignored.
  - abort returns to IDLE at the next edge: busy=0, match_cnt held, done stays 0. abort outranks a same-cycle in_valid, which is discarded.
  - Accepted bit: hist_n = {hist[PAT_W-2:0], in}; fill_n = min(fill+1, PAT_W).
  - Match condition: hist_n == pattern_q and fill_n == PAT_W.
  - On a match, at that same edge:
    - out <= 1 for exactly one cycle (latency: out is high the cycle after the completing bit's edge).
    - match_cnt increments, saturating at 2^CNT_W-1.
    - If overlap_q=0, fill <= 0 (hist is don't-care); if overlap_q=1, fill stays at PAT_W.
    - If target_q != 0 and match_cnt+1 == target_q, state goes to DONE, done=1 and busy=0 at the same edge.
  - in_valid=0 holds hist, fill and match_cnt; out returns to 0.
- DONE: further bits are ignored. done stays high until start or rst; cfg_load alone leaves done unchanged.
- out is 0 in every cycle not immediately following a match.

Decomposition:
- Package seq_det_pkg holds:
  - state encodings (IDLE/RUN/DONE)
  - default PAT_W/CNT_W localparams
  - a saturating-increment function
- Natural sub-module: seq_det_core. It holds the history shift register, fill counter and match compare, with clear, shift-enable and overlap inputs and a combinational match output.
- The controller FSM, counter and output registers stay in seq_det_ctrl.

Test Plan:
1. Overlapping matches. Config pattern=4'b1011, overlap=1, target=0; start; bits 1,0,1,1,0,1,1 back-to-back.
   Required: out pulses after bit 4 and bit 7, match_cnt=2, busy=1, done=0.
2. Non-overlapping. Same stream with overlap=0.
   Required: single pulse after bit 4, match_cnt=1; bits 5-7 leave fill=3 with no pulse.
3. Target stop. pattern=1011, overlap=1, target=2; bits 1,0,1,1,1,0,1,1,1,0,1,1.
   Required: pulses after bits 4 and 8; done=1 and busy=0 at the bit-8 edge; bits 9-12 produce no pulse and match_cnt stays 2.
4. Valid gaps. Bits 1,0 then in_valid=0 with in=1 for 3 cycles, then 1,1.
   Required: exactly one pulse, after the final bit.
5. Abort and re-arm. Abort after bits 1,0,1; abort is simultaneous with valid bit 1.
   Required: IDLE next edge, no pulse. Then start and feed 1.
   Required: no pulse (fill cleared). cfg_load during RUN with pattern=0000 is ignored; pattern stays 1011.
6. Reset. rst high for one cycle mid-pattern (fill=3), including a case where the match-completing bit arrives in the rst cycle.
   Required: no out pulse, all outputs 0 after the edge, config cleared (pattern_q=0).
